// File: rtl/router_pkg.sv
// Shared types and default sizing for the per-output-port arbiter.
package router_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int NUM_PORTS         = 8;
  localparam int STALL_MAX_DEFAULT = 64;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set bit searching upward
// from (ptr+1) mod NUM_REQ, wrapping around.
module rr_pick #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    w_cand = '0;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
    if (found) begin
      winner[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/outport_arbiter.sv
// Round-robin packet arbiter sharing one output FIFO among NUM_REQ inputs.
// Optional requester mask is enabled by defining OUTPORT_ARB_MASK_EN.
module outport_arbiter
  import router_pkg::*;
#(
  parameter int NUM_REQ   = NUM_PORTS,
  parameter int IDX_W     = $clog2(NUM_REQ),
  parameter int STALL_MAX = STALL_MAX_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] eop,
`ifdef OUTPORT_ARB_MASK_EN
  input  logic [NUM_REQ-1:0] mask,
`endif
  input  logic               fifo_full,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_vld,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               push,
  output logic               timeout
);

  localparam int STALL_W = 8;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     r_ptr;
  logic [STALL_W-1:0]   r_stall;
  logic                 r_timeout;

  state_t               w_state_next;
  logic [NUM_REQ-1:0]   w_grant_next;
  logic [IDX_W-1:0]     w_idx_next;
  logic [IDX_W-1:0]     w_ptr_next;
  logic [STALL_W-1:0]   w_stall_next;
  logic                 w_timeout_next;
  logic                 w_push;

  logic [NUM_REQ-1:0]   w_elig;
  logic                 w_found;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic [IDX_W-1:0]     w_win_idx;

`ifdef OUTPORT_ARB_MASK_EN
  assign w_elig = req & ~mask;
`else
  assign w_elig = req;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (w_elig),
    .ptr    (r_ptr),
    .found  (w_found),
    .winner (w_win_oh),
    .idx    (w_win_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_ptr     <= IDX_W'(NUM_REQ - 1);
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_grant   <= w_grant_next;
      r_idx     <= w_idx_next;
      r_ptr     <= w_ptr_next;
      r_stall   <= w_stall_next;
      r_timeout <= w_timeout_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_grant_next   = r_grant;
    w_idx_next     = r_idx;
    w_ptr_next     = r_ptr;
    w_stall_next   = r_stall;
    w_timeout_next = 1'b0;
    w_push         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_next = OWN;
          w_grant_next = w_win_oh;
          w_idx_next   = w_win_idx;
          w_ptr_next   = w_win_idx;
          w_stall_next = '0;
        end
      end
      OWN: begin
        w_push = req[r_idx] & ~fifo_full;
        if (w_push && eop[r_idx]) begin
          w_state_next = IDLE;
          w_grant_next = '0;
          w_idx_next   = '0;
          w_stall_next = '0;
        end else if (req[r_idx]) begin
          // A full FIFO with the owner still requesting is not a stall.
          w_stall_next = '0;
        end else if (r_stall == STALL_W'(STALL_MAX - 1)) begin
          w_state_next   = IDLE;
          w_grant_next   = '0;
          w_idx_next     = '0;
          w_stall_next   = '0;
          w_timeout_next = 1'b1;
        end else begin
          w_stall_next = r_stall + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_grant_next = '0;
        w_idx_next   = '0;
      end
    endcase
  end

  assign grant     = r_grant;
  assign grant_vld = (r_state == OWN);
  assign grant_idx = r_idx;
  assign push      = w_push;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_outport_arbiter.sv
// Directed self-checking bench for outport_arbiter (8 ports, STALL_MAX=4).
module tb_outport_arbiter;

  localparam int NREQ = 8;
  localparam int IW   = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] eop = '0;
  logic            fifo_full = 1'b0;
`ifdef OUTPORT_ARB_MASK_EN
  logic [NREQ-1:0] mask = '0;
`endif
  logic [NREQ-1:0] grant;
  logic            grant_vld;
  logic [IW-1:0]   grant_idx;
  logic            push;
  logic            timeout;

  int n_vec = 0;
  int n_err = 0;

  outport_arbiter #(
    .NUM_REQ   (NREQ),
    .IDX_W     (IW),
    .STALL_MAX (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .eop       (eop),
`ifdef OUTPORT_ARB_MASK_EN
    .mask      (mask),
`endif
    .fifo_full (fifo_full),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx),
    .push      (push),
    .timeout   (timeout)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; req = '0; eop = '0; fifo_full = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    n_vec++;
    if ({grant, grant_vld, grant_idx, push, timeout} !== 13'd0) begin
      n_err++;
      $display("FAIL reset: grant=%b vld=%b idx=%0d push=%b to=%b, want all zero",
               grant, grant_vld, grant_idx, push, timeout);
    end
    $display("reset: grant=%b vld=%b", grant, grant_vld);
  endtask

  task automatic test_single;
    do_reset();
    req = 8'b0000_0100;
    #1;
    n_vec++;
    if (grant !== 8'h00) begin n_err++; $display("FAIL single_latency: grant=%b want 00000000", grant); end
    tick();
    n_vec++;
    if (grant !== 8'b0000_0100 || grant_idx !== 3'd2 || grant_vld !== 1'b1) begin
      n_err++; $display("FAIL single_grant: grant=%b idx=%0d vld=%b want 00000100 2 1", grant, grant_idx, grant_vld);
    end
    for (int w = 0; w < 4; w++) begin
      eop = (w == 3) ? 8'b0000_0100 : 8'h00;
      #1;
      n_vec++;
      if (push !== 1'b1 || grant !== 8'b0000_0100) begin
        n_err++; $display("FAIL single_push%0d: push=%b grant=%b want 1 00000100", w, push, grant);
      end
      $display("single word %0d: push=%b eop=%b", w, push, eop[2]);
      tick();
    end
    req = '0; eop = '0;
    #1;
    n_vec++;
    if (grant !== 8'h00 || grant_vld !== 1'b0 || push !== 1'b0) begin
      n_err++; $display("FAIL single_release: grant=%b vld=%b push=%b want 0 0 0", grant, grant_vld, push);
    end
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] exp_g;
    do_reset();
    req = 8'hFF; eop = 8'hFF;
    tick();
    for (int k = 0; k <= NREQ; k++) begin
      exp_g = 8'h01 << (k % NREQ);
      n_vec++;
      if (grant !== exp_g || grant_idx !== IW'(k % NREQ) || push !== 1'b1) begin
        n_err++; $display("FAIL rr_grant%0d: grant=%b idx=%0d push=%b want %b %0d 1",
                          k, grant, grant_idx, push, exp_g, k % NREQ);
      end
      $display("rr step %0d: grant=%b idx=%0d", k, grant, grant_idx);
      tick();
      n_vec++;
      if (grant !== 8'h00 || push !== 1'b0) begin
        n_err++; $display("FAIL rr_idle%0d: grant=%b push=%b want 00000000 0", k, grant, push);
      end
      tick();
    end
    req = '0; eop = '0;
  endtask

  task automatic test_backpressure;
    do_reset();
    req = 8'b0010_0000;
    tick();
    n_vec++;
    if (grant !== 8'b0010_0000 || push !== 1'b1) begin
      n_err++; $display("FAIL bp_first: grant=%b push=%b want 00100000 1", grant, push);
    end
    tick();
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      eop = (c == 2) ? 8'b0010_0000 : 8'h00;
      #1;
      n_vec++;
      if (push !== 1'b0 || grant !== 8'b0010_0000 || timeout !== 1'b0) begin
        n_err++; $display("FAIL bp_full%0d: push=%b grant=%b to=%b want 0 00100000 0", c, push, grant, timeout);
      end
      $display("bp full cycle %0d: push=%b grant=%b", c, push, grant);
      tick();
    end
    fifo_full = 1'b0;
    #1;
    n_vec++;
    if (push !== 1'b1 || grant !== 8'b0010_0000 || timeout !== 1'b0) begin
      n_err++; $display("FAIL bp_resume: push=%b grant=%b to=%b want 1 00100000 0", push, grant, timeout);
    end
    tick();
    req = '0; eop = '0;
    #1;
    n_vec++;
    if (grant !== 8'h00) begin n_err++; $display("FAIL bp_release: grant=%b want 00000000", grant); end
  endtask

  task automatic test_stall_timeout;
    do_reset();
    req = 8'b0001_1000;
    tick();
    n_vec++;
    if (grant !== 8'b0000_1000 || grant_idx !== 3'd3) begin
      n_err++; $display("FAIL stall_grant: grant=%b idx=%0d want 00001000 3", grant, grant_idx);
    end
    tick();
    req = 8'b0001_0000;
    for (int s = 0; s < 4; s++) begin
      #1;
      n_vec++;
      if (grant !== 8'b0000_1000 || timeout !== 1'b0 || push !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d: grant=%b to=%b push=%b want 00001000 0 0", s, grant, timeout, push);
      end
      tick();
    end
    n_vec++;
    if (grant !== 8'h00 || timeout !== 1'b1 || grant_vld !== 1'b0) begin
      n_err++; $display("FAIL stall_revoke: grant=%b to=%b vld=%b want 00000000 1 0", grant, timeout, grant_vld);
    end
    $display("stall revoke: grant=%b timeout=%b", grant, timeout);
    tick();
    n_vec++;
    if (grant !== 8'b0001_0000 || grant_idx !== 3'd4 || timeout !== 1'b0) begin
      n_err++; $display("FAIL stall_next: grant=%b idx=%0d to=%b want 00010000 4 0", grant, grant_idx, timeout);
    end
    req = '0;
  endtask

  task automatic test_reset_mid_packet;
    do_reset();
    req = 8'b0100_0000;
    tick();
    n_vec++;
    if (grant !== 8'b0100_0000 || push !== 1'b1) begin
      n_err++; $display("FAIL rstmid_own: grant=%b push=%b want 01000000 1", grant, push);
    end
    reset = 1'b1;
    tick();
    n_vec++;
    if (grant !== 8'h00 || push !== 1'b0 || grant_vld !== 1'b0) begin
      n_err++; $display("FAIL rstmid_drop: grant=%b push=%b vld=%b want 00000000 0 0", grant, push, grant_vld);
    end
    reset = 1'b0;
    req = 8'b1000_0001;
    tick();
    n_vec++;
    if (grant !== 8'b0000_0001 || grant_idx !== 3'd0) begin
      n_err++; $display("FAIL rstmid_regrant: grant=%b idx=%0d want 00000001 0", grant, grant_idx);
    end
    $display("reset mid packet: regrant=%b", grant);
    req = '0;
  endtask

`ifdef OUTPORT_ARB_MASK_EN
  task automatic test_mask;
    do_reset();
    mask = 8'b0000_0001; req = 8'b0000_0011;
    tick();
    n_vec++;
    if (grant !== 8'b0000_0010) begin n_err++; $display("FAIL mask_grant: grant=%b want 00000010", grant); end
    mask = 8'b0000_0011;
    #1;
    n_vec++;
    if (push !== 1'b1) begin n_err++; $display("FAIL mask_nopreempt: push=%b want 1", push); end
    tick();
    n_vec++;
    if (grant !== 8'b0000_0010) begin n_err++; $display("FAIL mask_hold: grant=%b want 00000010", grant); end
    eop = 8'b0000_0010;
    tick();
    mask = 8'hFF; req = 8'hFF; eop = '0;
    tick();
    n_vec++;
    if (grant !== 8'h00 || grant_vld !== 1'b0) begin
      n_err++; $display("FAIL mask_all: grant=%b vld=%b want 00000000 0", grant, grant_vld);
    end
    $display("mask all ones: grant=%b", grant);
    mask = '0; req = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_stall_timeout();
    test_reset_mid_packet();
`ifdef OUTPORT_ARB_MASK_EN
    test_mask();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
